// File: rtl/p12_scan_pkg.sv
// p12_scan_pkg: shared types and constants for the tile-array scan controller.
//   op_e    : command opcodes carried on cmd_op
//   state_e : controller FSM states
//   P12_CHAIN_LEN : default number of tiles in the scan chain (informational)
//   BYTE_W  : width of a command operand / readback byte
package p12_scan_pkg;

    localparam int unsigned P12_CHAIN_LEN = 36;
    localparam int unsigned BYTE_W        = 8;

    typedef enum logic [1:0] {
        OP_SHIFT = 2'b00,
        OP_LATCH = 2'b01,
        OP_RUN   = 2'b10,
        OP_LB    = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LAT_ON,
        ST_LAT_OFF,
        ST_RUN
    } state_e;

endpackage

// File: rtl/p12_scan_shreg.sv
// p12_scan_shreg: 8-bit serializer/deserializer for the scan chain.
//   Optional feature macro: SCAN_READBACK_EN (builds the capture register).
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   load_i       load din_i; bit 0 is sent directly by the controller
//   din_i        byte to serialize
//   shift_i      advance the serializer by one bit
//   tx_bit_o     next bit to present on the scan input
//   capture_i    shift ret_i into the capture register
//   ret_i        serial bit returning from the last tile
//   rx_next_o    capture register value after this edge's capture
module p12_scan_shreg
    import p12_scan_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [BYTE_W-1:0] din_i,
    input  logic              shift_i,
    output logic              tx_bit_o,
    input  logic              capture_i,
    input  logic              ret_i,
    output logic [BYTE_W-1:0] rx_next_o
);

    logic [BYTE_W-1:0] tx_q;
    logic [BYTE_W-1:0] tx_d;

    // Bit 0 leaves via the controller on the load edge, so only bits 7..1 are kept.
    always_comb begin
        tx_d = tx_q;
        if (load_i) begin
            tx_d = {1'b0, din_i[BYTE_W-1:1]};
        end else if (shift_i) begin
            tx_d = {1'b0, tx_q[BYTE_W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q <= '0;
        end else begin
            tx_q <= tx_d;
        end
    end

    assign tx_bit_o = tx_q[0];

`ifdef SCAN_READBACK_EN
    logic [BYTE_W-1:0] rx_q;

    // LSB-first capture: the first returned bit ends up in bit 0 after 8 edges.
    assign rx_next_o = {ret_i, rx_q[BYTE_W-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q <= '0;
        end else if (capture_i) begin
            rx_q <= rx_next_o;
        end
    end
`else
    logic unused_rx;
    assign unused_rx = ret_i ^ capture_i;
    assign rx_next_o = '0;
`endif

endmodule

// File: rtl/p12_scan_ctrl.sv
// p12_scan_ctrl: host-side driver for the tile-array scan chain and
// configuration latches. Byte commands arrive on a valid/ready port and are
// executed as SHIFT (8 scan bits), LATCH (strobe pulse), RUN (N fabric
// cycles) or LB (loop-breaker level). All outputs are registered.
//   Optional feature macro: SCAN_READBACK_EN (scan_ret readback on rd_*).
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake; ready only in IDLE
//   cmd_op, cmd_data    opcode (op_e) and operand
//   scan_se, scan_sc    scan enable and serial data into the first tile
//   scan_ret            serial data from the last tile
//   fab_clk_en          enable for the external fabric clock gate
//   cfg_v/cfg_h/cfg_d   vertical/horizontal/diagonal latch strobes
//   lb                  loop breaker, held between LB commands
//   rd_valid, rd_data   one-cycle readback of the bits returned during SHIFT
//   busy                inverse of cmd_ready
module p12_scan_ctrl
    import p12_scan_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = P12_CHAIN_LEN,
    parameter int unsigned RUN_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [BYTE_W-1:0] cmd_data,
    output logic              scan_se,
    output logic              scan_sc,
    input  logic              scan_ret,
    output logic              fab_clk_en,
    output logic              cfg_v,
    output logic              cfg_h,
    output logic              cfg_d,
    output logic              lb,
    output logic              rd_valid,
    output logic [BYTE_W-1:0] rd_data,
    output logic              busy
);

    // Chain length is informational; nothing here depends on it.
    localparam int unsigned chain_len_unused = CHAIN_LEN;

    state_e             state_q, state_d;
    logic [RUN_W-1:0]   cnt_q, cnt_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               busy_q, busy_d;
    logic               scan_se_q, scan_se_d;
    logic               scan_sc_q, scan_sc_d;
    logic               fab_clk_en_q, fab_clk_en_d;
    logic [2:0]         strobe_q, strobe_d;   // {d, h, v}
    logic               lb_q, lb_d;
    logic               rd_valid_q, rd_valid_d;
    logic [BYTE_W-1:0]  rd_data_q, rd_data_d;

    logic               sh_load;
    logic               sh_shift;
    logic               tx_bit;
    logic [BYTE_W-1:0]  rx_next;

    p12_scan_shreg u_shreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (sh_load),
        .din_i     (cmd_data),
        .shift_i   (sh_shift),
        .tx_bit_o  (tx_bit),
        .capture_i (sh_shift),
        .ret_i     (scan_ret),
        .rx_next_o (rx_next)
    );

`ifndef SCAN_READBACK_EN
    logic unused_rx;
    assign unused_rx = ^rx_next;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        scan_se_d    = 1'b0;
        scan_sc_d    = 1'b0;
        fab_clk_en_d = 1'b0;
        strobe_d     = 3'b000;
        lb_d         = lb_q;
        rd_valid_d   = 1'b0;
        rd_data_d    = rd_data_q;
        sh_load      = 1'b0;
        sh_shift     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    unique case (op_e'(cmd_op))
                        OP_SHIFT: begin
                            state_d      = ST_SHIFT;
                            cnt_d        = RUN_W'(BYTE_W - 1);
                            sh_load      = 1'b1;
                            scan_se_d    = 1'b1;
                            scan_sc_d    = cmd_data[0];
                            fab_clk_en_d = 1'b1;
                        end
                        OP_LATCH: begin
                            state_d  = ST_LAT_ON;
                            strobe_d = cmd_data[2:0];
                        end
                        OP_RUN: begin
                            // Operand 0 wraps to all-ones, giving 256 cycles.
                            state_d      = ST_RUN;
                            cnt_d        = RUN_W'(cmd_data) - RUN_W'(1);
                            fab_clk_en_d = 1'b1;
                        end
                        OP_LB: begin
                            lb_d = cmd_data[0];
                        end
                        default: ;
                    endcase
                end
            end
            ST_SHIFT: begin
                sh_shift = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
`ifdef SCAN_READBACK_EN
                    rd_valid_d = 1'b1;
                    rd_data_d  = rx_next;
`endif
                end else begin
                    cnt_d        = cnt_q - RUN_W'(1);
                    scan_se_d    = 1'b1;
                    scan_sc_d    = tx_bit;
                    fab_clk_en_d = 1'b1;
                end
            end
            ST_LAT_ON: begin
                state_d = ST_LAT_OFF;
            end
            ST_LAT_OFF: begin
                state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d        = cnt_q - RUN_W'(1);
                    fab_clk_en_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = ~cmd_ready_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            scan_se_q    <= 1'b0;
            scan_sc_q    <= 1'b0;
            fab_clk_en_q <= 1'b0;
            strobe_q     <= 3'b000;
            lb_q         <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
            scan_se_q    <= scan_se_d;
            scan_sc_q    <= scan_sc_d;
            fab_clk_en_q <= fab_clk_en_d;
            strobe_q     <= strobe_d;
            lb_q         <= lb_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;
    assign scan_se    = scan_se_q;
    assign scan_sc    = scan_sc_q;
    assign fab_clk_en = fab_clk_en_q;
    assign cfg_v      = strobe_q[0];
    assign cfg_h      = strobe_q[1];
    assign cfg_d      = strobe_q[2];
    assign lb         = lb_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;

endmodule
